// File: rtl/col_acc_pkg.sv
// ---------------------------------------------------------------
// col_acc_pkg : shared sizes and state type for col_acc256 - rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package col_acc_pkg;

  localparam int NCOL  = 256;
  localparam int COL_W = 10;
  localparam int CNT_W = $clog2(NCOL);
  localparam int RES_W = NCOL + COL_W;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/col_acc_step.sv
// ---------------------------------------------------------------
// col_acc_step : one column fold, {carry, col} -> {bit, next carry} - rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module col_acc_step
  import col_acc_pkg::*;
(
  input  logic [COL_W-1:0] carry,
  input  logic [COL_W-1:0] col,
  output logic             res_bit,
  output logic [COL_W-1:0] next_carry
);

  // carry <= 1023 and col <= 1023 keep the sum <= 2046, so the shifted
  // carry always fits back into COL_W bits.
  logic [COL_W:0] sum;

  always_comb begin
    sum        = {1'b0, carry} + {1'b0, col};
    res_bit    = sum[0];
    next_carry = sum[COL_W:1];
  end

endmodule

`default_nettype wire

// File: rtl/col_acc256.sv
// ---------------------------------------------------------------
// col_acc256 : folds 256 column weights (LSB first) into a 266-bit integer
// Optional feature: COL_ACC_ABORT_EN adds an 'abort' input - rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module col_acc256
  import col_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
`ifdef COL_ACC_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COL_W-1:0] col_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res,
  output logic             busy
);

  acc_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] carry;
  logic [NCOL-1:0]  bits;

  logic             step_bit;
  logic [COL_W-1:0] step_carry;
  logic [NCOL-1:0]  bits_shifted;

  logic             abort_req;
  logic             accept;
  logic             last;
  logic             clear;

`ifdef COL_ACC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  col_acc_step u_step (
    .carry      (carry),
    .col        (col_in),
    .res_bit    (step_bit),
    .next_carry (step_carry)
  );

  assign bits_shifted = {step_bit, bits[NCOL-1:1]};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    clear     = 1'b0;
    case (state)
      ACC: begin
        if (abort_req) begin
          clear = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (cnt == CNT_W'(NCOL - 1)) begin
            last      = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          clear     = 1'b1;
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      cnt   <= '0;
      carry <= '0;
      bits  <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        cnt   <= '0;
        carry <= '0;
        bits  <= '0;
      end else if (accept) begin
        bits  <= bits_shifted;
        carry <= step_carry;
        cnt   <= last ? '0 : cnt + 1'b1;
        // The final carry is the top of the result; no flush column needed.
        if (last) begin
          res <= {step_carry, bits_shifted};
        end
      end
    end
  end

  assign in_ready  = (state == ACC);
  assign res_valid = (state == HOLD);
  assign busy      = (state == ACC) && (cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_col_acc256.sv
// ---------------------------------------------------------------
// tb_col_acc256 : directed scoreboard bench for col_acc256 - rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_col_acc256;
  import col_acc_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic [COL_W-1:0] col_in = '0;
  logic             in_ready;
  logic             res_valid;
  logic             busy;
  logic [RES_W-1:0] res;
`ifdef COL_ACC_ABORT_EN
  logic             abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [RES_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  col_acc256 dut (
    .clk       (clk),
    .rst       (rst),
`ifdef COL_ACC_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .col_in    (col_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .busy      (busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_w(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a full operand and pushes the arithmetic sum of col_i*2^i.
  // mode 0: every column = v; mode 1: column 0 = v, the rest 0.
  task automatic send_op(input int mode, input int v, input int gap_at);
    logic [RES_W-1:0] e;
    logic [RES_W-1:0] term;
    logic [COL_W-1:0] val;
    e = '0;
    for (int i = 0; i < NCOL; i++) begin
      val  = (mode == 0 || i == 0) ? COL_W'(v) : '0;
      term = '0;
      term[COL_W-1:0] = val;
      e = e + (term << i);
      if (i == gap_at) begin
        in_valid = 1'b0;
        col_in   = 10'h2AA;
        tick();
        tick();
        check_b("gap_busy_held", busy, 1'b1);
      end
      in_valid = 1'b1;
      col_in   = val;
      tick();
      if (i == 0) check_b("busy_after_first", busy, 1'b1);
    end
    in_valid = 1'b0;
    exp_q.push_back(e);
    check_b("res_valid_zero_latency", res_valid, 1'b1);
  endtask

  task automatic send_cols(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      col_in   = COL_W'(v);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Consumes one result, optionally stalling res_ready for 'stall' cycles
  // while junk columns are offered.
  task automatic get_result(input string tag, input int stall);
    logic [RES_W-1:0] e;
    logic [RES_W-1:0] held;
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check_b({tag, "_valid"}, res_valid, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_w({tag, "_res"}, res, e);
    check_b({tag, "_in_ready_low"}, in_ready, 1'b0);
    held = e;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      col_in   = 10'h155;
      tick();
      check_w({tag, "_stall_res"}, res, held);
      check_b({tag, "_stall_valid"}, res_valid, 1'b1);
      check_b({tag, "_stall_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_b({tag, "_valid_cleared"}, res_valid, 1'b0);
    check_b({tag, "_in_ready_back"}, in_ready, 1'b1);
    check_b({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  logic [RES_W-1:0] ones256;
  logic [RES_W-1:0] max_exp;

  initial begin
    ones256 = '0;
    ones256[NCOL-1:0] = '1;
    max_exp = {10'h3FE, ones256[NCOL-1:0] - 256'd1022};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_b("reset_res_valid", res_valid, 1'b0);
    check_w("reset_res", res, '0);
    check_b("reset_in_ready", in_ready, 1'b1);
    check_b("reset_busy", busy, 1'b0);

    send_op(0, 1, -1);
    check_w("model_all_ones", exp_q[0], ones256);
    get_result("all_ones", 0);

    send_op(1, 1023, -1);
    get_result("col0_max", 0);

    send_op(0, 1023, 50);
    check_w("model_all_max", exp_q[0], max_exp);
    get_result("all_max", 0);
    check_w("all_max_top", {256'd0, res[RES_W-1:NCOL]}, 266'h3FE);

    send_op(0, 3, -1);
    get_result("stall", 5);
    send_op(0, 2, -1);
    get_result("all_twos", 0);

    send_cols(100, 1);
    check_b("partial_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_b("midreset_busy", busy, 1'b0);
    check_b("midreset_in_ready", in_ready, 1'b1);
    send_op(0, 1, -1);
    get_result("after_reset", 0);

`ifdef COL_ACC_ABORT_EN
    send_cols(100, 1023);
    abort    = 1'b1;
    in_valid = 1'b1;
    col_in   = 10'h3FF;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_b("abort_busy", busy, 1'b0);
    send_op(0, 1, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_b("abort_in_hold_ignored", res_valid, 1'b1);
    get_result("after_abort", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
